// File: rtl/mmio_port_responder_if.sv
// Processor data-memory bus as seen by the MMIO port responder.
// The processor drives address/data/strobes; the responder returns ReadData and Hit combinationally.
interface mmio_port_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  ReadData, Hit
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output ReadData, Hit
    );
endinterface

// File: rtl/mmio_port_responder.sv
// Four-register MMIO window: output port, synchronized input port, W1C change status and optional timer.
// Define MMIO_PORT_TIMER_EN to build the free-running TIMER at offset 0xC; otherwise that offset reads 0.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    mmio_port_responder_if.slave bus,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                ChangeIrq
);

    localparam logic [1:0] SEL_PORT_OUT = 2'd0;
    localparam logic [1:0] SEL_PORT_IN  = 2'd1;
    localparam logic [1:0] SEL_STATUS   = 2'd2;
    localparam logic [1:0] SEL_TIMER    = 2'd3;

    logic                w_hit;
    logic [1:0]          w_sel;
    logic                w_wr;
    logic                w_change;
    logic                w_chg_clear;
    logic [31:0]         w_port_in_ext;
    logic [31:0]         w_timer;
    logic [31:0]         w_rd_mux;
    logic                w_unused;

    logic [31:0]         r_port_out;
    logic [IN_WIDTH-1:0] r_sync1;
    logic [IN_WIDTH-1:0] r_sync2;
    logic [IN_WIDTH-1:0] r_prev;
    logic                r_chg;

    // Byte offset bits [1:0] never select anything.
    assign w_unused    = &{1'b0, bus.Address[1:0]};

    assign w_hit       = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign w_sel       = bus.Address[3:2];
    assign w_wr        = bus.MemWrite & w_hit;
    assign w_change    = (r_sync2 != r_prev);
    assign w_chg_clear = w_wr && (w_sel == SEL_STATUS) && bus.WriteData[0];

    always_comb begin
        w_port_in_ext                = '0;
        w_port_in_ext[IN_WIDTH-1:0]  = r_sync2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_chg      <= 1'b0;
        end else begin
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_wr && (w_sel == SEL_PORT_OUT))
                r_port_out <= bus.WriteData;
            // A newly detected change beats a simultaneous W1C clear.
            if (w_change)
                r_chg <= 1'b1;
            else if (w_chg_clear)
                r_chg <= 1'b0;
        end
    end

`ifdef MMIO_PORT_TIMER_EN
    logic [31:0] r_timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_timer <= '0;
        else if (w_wr && (w_sel == SEL_TIMER))
            r_timer <= bus.WriteData;
        else
            r_timer <= r_timer + 32'd1;
    end

    assign w_timer = r_timer;
`else
    assign w_timer = '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            SEL_PORT_OUT: w_rd_mux = r_port_out;
            SEL_PORT_IN:  w_rd_mux = w_port_in_ext;
            SEL_STATUS:   w_rd_mux = {31'd0, r_chg};
            SEL_TIMER:    w_rd_mux = w_timer;
            default:      w_rd_mux = '0;
        endcase
    end

    assign bus.ReadData = (bus.MemRead && w_hit) ? w_rd_mux : 32'h0;
    assign bus.Hit      = w_hit;
    assign PortOut      = r_port_out;
    assign ChangeIrq    = r_chg;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: vector table for single-cycle accesses,
// hand-written sequences for synchronizer, W1C, timer and asynchronous reset behaviour.
module tb_mmio_port_responder;

    logic        clk;
    logic        reset;
    logic [7:0]  port_in;
    logic [31:0] port_out;
    logic        change_irq;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    mmio_port_responder_if bus_if ();

    mmio_port_responder #(
        .BASE_ADDR (32'hFFFF0000),
        .IN_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .PortIn    (port_in),
        .PortOut   (port_out),
        .ChangeIrq (change_irq)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check_rd(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %h expected <scoreboard empty>", name, bus_if.ReadData);
        end else begin
            e = exp_q.pop_front();
            check(name, bus_if.ReadData, e);
        end
    endtask

    // Driver: inputs change on the falling edge, away from the active edge.
    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic re);
        @(negedge clk);
        bus_if.Address   = addr;
        bus_if.WriteData = wdata;
        bus_if.MemWrite  = we;
        bus_if.MemRead   = re;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        port_in = 8'h00;
        bus_if.Address   = 32'h0;
        bus_if.WriteData = 32'h0;
        bus_if.MemWrite  = 1'b0;
        bus_if.MemRead   = 1'b0;

        // addr, wdata, we, re, exp_rd, exp_hit, exp PortOut after edge
        vecs[0]  = '{32'hFFFF0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 32'h0};
        vecs[1]  = '{32'hFFFF0000, 32'hA5A50F0F, 1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A50F0F};
        vecs[2]  = '{32'hFFFF0000, 32'h0,        1'b0, 1'b1, 32'hA5A50F0F, 1'b1, 32'hA5A50F0F};
        vecs[3]  = '{32'hFFFF0003, 32'h0,        1'b0, 1'b1, 32'hA5A50F0F, 1'b1, 32'hA5A50F0F};
        vecs[4]  = '{32'hFFFF0000, 32'h12345678, 1'b1, 1'b1, 32'hA5A50F0F, 1'b1, 32'h12345678};
        vecs[5]  = '{32'h10010000, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0,        1'b0, 32'h12345678};
        vecs[6]  = '{32'hFFFF0004, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 32'h12345678};
        vecs[7]  = '{32'hFFFF0008, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        1'b1, 32'h12345678};
        vecs[8]  = '{32'hFFFF0004, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0,        1'b1, 32'h12345678};
        vecs[9]  = '{32'hFFFF0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h12345678};
        vecs[10] = '{32'hFFFE0000, 32'h55555555, 1'b1, 1'b1, 32'h0,        1'b0, 32'h12345678};
        vecs[11] = '{32'hFFFF0001, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1, 32'h12345678};

        // Reset state
        #12;
        check("reset_portout", port_out, 32'h0);
        check("reset_irq", {31'd0, change_irq}, 32'h0);
        bus_if.Address = 32'hFFFF0000;
        bus_if.MemRead = 1'b1;
        #1;
        check("reset_readdata", bus_if.ReadData, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_if.MemRead = 1'b0;

        // Table-driven single-cycle accesses
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
            sb_push(vecs[i].exp_rd);
            #2;
            sb_check_rd($sformatf("vec%0d_rd", i));
            check($sformatf("vec%0d_hit", i), {31'd0, bus_if.Hit}, {31'd0, vecs[i].exp_hit});
            edge_settle();
            check($sformatf("vec%0d_out", i), port_out, vecs[i].exp_out);
        end
        check("no_spurious_chg", {31'd0, change_irq}, 32'h0);

        // PortIn 00 -> 3C: visible in PORT_IN at edge 2, CHG at edge 3
        @(negedge clk);
        port_in          = 8'h3C;
        bus_if.Address   = 32'hFFFF0004;
        bus_if.MemWrite  = 1'b0;
        bus_if.MemRead   = 1'b1;
        edge_settle();
        sb_push(32'h0);      sb_check_rd("sync_e1_rd");
        check("sync_e1_irq", {31'd0, change_irq}, 32'h0);
        edge_settle();
        sb_push(32'h3C);     sb_check_rd("sync_e2_rd");
        check("sync_e2_irq", {31'd0, change_irq}, 32'h0);
        edge_settle();
        check("sync_e3_irq", {31'd0, change_irq}, 32'h1);
        drive(32'hFFFF0008, 32'h0, 1'b0, 1'b1);
        sb_push(32'h1);
        #2;
        sb_check_rd("status_rd_set");
        drive(32'hFFFF0008, 32'h1, 1'b1, 1'b0);
        edge_settle();
        check("w1c_clear", {31'd0, change_irq}, 32'h0);
        idle();
        edge_settle();
        check("chg_stays_clear", {31'd0, change_irq}, 32'h0);

        // W1C write in the same cycle as a newly detected change: set wins
        @(negedge clk);
        port_in = 8'hC3;
        edge_settle();
        edge_settle();
        drive(32'hFFFF0008, 32'h1, 1'b1, 1'b0);
        edge_settle();
        check("w1c_vs_set", {31'd0, change_irq}, 32'h1);
        drive(32'hFFFF0008, 32'hFFFFFFFE, 1'b1, 1'b0);
        edge_settle();
        check("w0_no_clear", {31'd0, change_irq}, 32'h1);
        drive(32'hFFFF0008, 32'h1, 1'b1, 1'b0);
        edge_settle();
        check("w1c_clear2", {31'd0, change_irq}, 32'h0);

        // Timer: load FFFFFFFE then wrap
        drive(32'hFFFF000C, 32'hFFFFFFFE, 1'b1, 1'b0);
        edge_settle();
        bus_if.MemWrite = 1'b0;
        bus_if.MemRead  = 1'b1;
`ifdef MMIO_PORT_TIMER_EN
        sb_push(32'hFFFFFFFE);
        sb_push(32'hFFFFFFFF);
        sb_push(32'h00000000);
`else
        sb_push(32'h0);
        sb_push(32'h0);
        sb_push(32'h0);
`endif
        #1;
        sb_check_rd("timer_c0");
        edge_settle();
        sb_check_rd("timer_c1");
        edge_settle();
        sb_check_rd("timer_c2");
        check("timer_portout_kept", port_out, 32'h12345678);

        // Random PORT_OUT stores read back through the scoreboard
        for (int i = 0; i < 6; i++) begin
            logic [31:0] v;
            v = $urandom_range(0, 32'h7FFFFFFF) ^ (32'(i) << 31);
            drive(32'hFFFF0000 | 32'($urandom_range(0, 3)), v, 1'b1, 1'b0);
            edge_settle();
            drive(32'hFFFF0000, 32'h0, 1'b0, 1'b1);
            sb_push(v);
            #2;
            sb_check_rd($sformatf("rand%0d_rd", i));
            check($sformatf("rand%0d_out", i), port_out, v);
        end

        // Asynchronous reset between edges abandons a pending write
        drive(32'hFFFF0000, 32'h0BADF00D, 1'b1, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_portout", port_out, 32'h0);
        check("async_rst_irq", {31'd0, change_irq}, 32'h0);
        sb_push(32'h0);
        sb_check_rd("async_rst_rd");
        @(posedge clk);
        #1;
        check("rst_held_portout", port_out, 32'h0);
        @(negedge clk);
        bus_if.MemWrite = 1'b0;
        port_in = 8'h00;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) edge_settle();
        check("post_rst_irq", {31'd0, change_irq}, 32'h0);
        check("post_rst_portout", port_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
